// File: rtl/q_ser_pkg.sv
// rtl/q_ser_pkg.sv - shared constants, state encoding and helpers for the charge-pulse serializer
package q_ser_pkg;

  localparam int unsigned DEF_BUS_WIDTH      = 10;
  localparam int unsigned DEF_Q_PER_PULSE    = 10;
  localparam int unsigned DEF_PULSE_DURATION = 3;
  localparam int unsigned DEF_GAP_DURATION   = 3;

  // Named view of the serializer states; the FSM register uses the matching constants below.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } q_state_e;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Number of pulses a given charge turns into.
  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/q_pulse_serializer_phase_timer.sv
// rtl/q_pulse_serializer_phase_timer.sv - loadable down-counter timing the high and gap phases
module phase_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expired
);

  logic [W-1:0] count;

  // Count down while enabled; a load takes priority and a stalled enable freezes the count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (en) begin
      if (load) begin
        count <= load_value;
      end else if (count != '0) begin
        count <= count - 1'b1;
      end
    end
  end

  // The phase ends on the cycle the count sits at 1, which also covers a load of 1.
  assign expired = (count == W'(1));

endmodule

// File: rtl/q_pulse_serializer.sv
// rtl/q_pulse_serializer.sv - turns a charge word into ceil(q/Q_PER_PULSE) fixed-width pulses
module q_pulse_serializer
  import q_ser_pkg::*;
#(
  parameter int unsigned BUS_WIDTH      = DEF_BUS_WIDTH,
  parameter int unsigned Q_PER_PULSE    = DEF_Q_PER_PULSE,
  parameter int unsigned PULSE_DURATION = DEF_PULSE_DURATION,
  parameter int unsigned GAP_DURATION   = DEF_GAP_DURATION
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 q_valid,
  input  logic [BUS_WIDTH-1:0] q_in,
  output logic                 q_ready,
  output logic                 q_serialized,
  output logic                 busy,
  output logic [BUS_WIDTH-1:0] pulse_count,
  output logic                 pulses_ended
);

  localparam int unsigned PHASE_MAX = (PULSE_DURATION > GAP_DURATION) ? PULSE_DURATION : GAP_DURATION;
  localparam int unsigned TW        = $clog2(PHASE_MAX + 1);

  localparam logic [TW-1:0]        PULSE_LOAD = TW'(PULSE_DURATION);
  localparam logic [TW-1:0]        GAP_LOAD   = TW'(GAP_DURATION);
  localparam logic [BUS_WIDTH-1:0] PC_MAX     = {BUS_WIDTH{1'b1}};

  logic [1:0]           state;
  logic [BUS_WIDTH-1:0] rem;
  logic [BUS_WIDTH-1:0] rem_next;
  logic                 accept;
  logic                 timer_load;
  logic [TW-1:0]        timer_value;
  logic                 timer_expired;

  // q_ready is only high in IDLE, so this is the single place a word is taken.
  assign accept = enable && q_valid && q_ready;

  // Charge left after the current pulse, floored at zero so a partial last pulse cannot wrap.
  always_comb begin
    rem_next = '0;
    if (32'(rem) > Q_PER_PULSE) begin
      rem_next = rem - BUS_WIDTH'(Q_PER_PULSE);
    end
  end

  // Reload the phase timer whenever a new high or gap phase starts.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = PULSE_LOAD;
    case (state)
      S_IDLE: timer_load = accept && (q_in != '0);
      S_HIGH: begin
        if (timer_expired && (rem_next != '0)) begin
          timer_load  = 1'b1;
          timer_value = GAP_LOAD;
        end
      end
      S_GAP:   timer_load = timer_expired;
      default: timer_load = 1'b0;
    endcase
  end

  phase_timer #(
    .W(TW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .en         (enable),
    .load       (timer_load),
    .load_value (timer_value),
    .expired    (timer_expired)
  );

  // Main FSM; outputs are registered on the transition into each state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      rem          <= '0;
      q_ready      <= 1'b1;
      q_serialized <= 1'b0;
      busy         <= 1'b0;
      pulse_count  <= '0;
      pulses_ended <= 1'b0;
    end else if (enable) begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            rem         <= q_in;
            pulse_count <= '0;
            q_ready     <= 1'b0;
            busy        <= 1'b1;
            if (q_in != '0) begin
              state        <= S_HIGH;
              q_serialized <= 1'b1;
            end else begin
              state        <= S_DONE;
              pulses_ended <= 1'b1;
            end
          end
        end
        S_HIGH: begin
          if (timer_expired) begin
            rem          <= rem_next;
            q_serialized <= 1'b0;
            if (pulse_count != PC_MAX) begin
              pulse_count <= pulse_count + 1'b1;
            end
            if (rem_next != '0) begin
              state <= S_GAP;
            end else begin
              state        <= S_DONE;
              pulses_ended <= 1'b1;
            end
          end
        end
        S_GAP: begin
          if (timer_expired) begin
            state        <= S_HIGH;
            q_serialized <= 1'b1;
          end
        end
        S_DONE: begin
          state        <= S_IDLE;
          pulses_ended <= 1'b0;
          q_ready      <= 1'b1;
          busy         <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
